// File: rtl/time_set_ctrl_pkg.sv
// Shared types and BCD helpers for the time-set editor.
// States, field limits, blink masks and digit positions of the {h2,h1,m2,m1,s2,s1} packing.
package time_set_pkg;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_SET_HR  = 3'd1;
   localparam logic [2:0] ST_SET_MIN = 3'd2;
   localparam logic [2:0] ST_SET_SEC = 3'd3;
   localparam logic [2:0] ST_COMMIT  = 3'd4;

   typedef enum logic [2:0] {
      IDLE    = ST_IDLE,
      SET_HR  = ST_SET_HR,
      SET_MIN = ST_SET_MIN,
      SET_SEC = ST_SET_SEC,
      COMMIT  = ST_COMMIT
   } state_e;

   localparam logic [7:0] HR_MAX = 8'h23;
   localparam logic [7:0] MS_MAX = 8'h59;

   localparam logic [5:0] MASK_HR  = 6'b110000;
   localparam logic [5:0] MASK_MIN = 6'b001100;
   localparam logic [5:0] MASK_SEC = 6'b000011;

   localparam int H2_LSB = 20;
   localparam int H1_LSB = 16;
   localparam int M2_LSB = 12;
   localparam int M1_LSB = 8;
   localparam int S2_LSB = 4;
   localparam int S1_LSB = 0;

   // Two-digit BCD step with wrap at the field limit; never goes through binary.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
      if (v == max) return 8'h00;
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
      if (v == 8'h00) return max;
      if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

   function automatic logic [5:0] field_mask(input state_e s);
      case (s)
         SET_HR:  return MASK_HR;
         SET_MIN: return MASK_MIN;
         SET_SEC: return MASK_SEC;
         default: return 6'b000000;
      endcase
   endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Load bus from the time-set editor to the wall-clock counter.
// load is a single-cycle strobe with no back-pressure: set_time is valid in exactly the cycle load is high.
interface time_set_ctrl_if;
   logic [23:0] set_time;
   logic        load;

   modport master (output set_time, load);
   modport slave  (input  set_time, load);
endinterface

// File: rtl/time_set_ctrl_btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and rising-edge press pulse.
// A new level is accepted after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic          sync0, sync1, level_d;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync0   <= 1'b0;
         sync1   <= 1'b0;
         level   <= 1'b0;
         level_d <= 1'b0;
         cnt     <= '0;
      end else begin
         sync0   <= raw;
         sync1   <= sync0;
         level_d <= level;
         if (sync1 != level) begin
            if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               level <= sync1;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign press = level & ~level_d;

endmodule

// File: rtl/time_set_ctrl.sv
// Time-set editor: debounced keys drive an IDLE/SET_HR/SET_MIN/SET_SEC/COMMIT walk over a BCD shadow time.
// Optional build macro AUTO_REPEAT_EN adds hold-to-repeat on the inc/dec keys.
module time_set_ctrl
   import time_set_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int BLINK_CYCLES    = 12500000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            btn_mode,
   input  logic            btn_inc,
   input  logic            btn_dec,
   input  logic            btn_cancel,
   input  logic [23:0]     cur_time,
   time_set_ctrl_if.master bus,
   output logic            editing,
   output logic [5:0]      blink_mask,
   output logic [2:0]      state
);
   localparam int BW = $clog2(BLINK_CYCLES + 1);

   logic [3:0] raw, lvl, prs;
   logic       mode_p, inc_p, dec_p, cancel_p;
   logic       inc_step, dec_step, step_any, do_arith, editing_nx;
   logic       unused_lvl;
   state_e     st, st_nx;
   logic [23:0] shadow;
   logic [7:0]  fld, fld_max, fld_nx;
   logic        phase;
   logic [BW-1:0] bcnt, hold;

   assign raw = {btn_cancel, btn_dec, btn_inc, btn_mode};

   for (genvar g = 0; g < 4; g++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk   (clk),
         .reset (reset),
         .raw   (raw[g]),
         .level (lvl[g]),
         .press (prs[g])
      );
   end

   assign mode_p     = prs[0];
   assign inc_p      = prs[1];
   assign dec_p      = prs[2];
   assign cancel_p   = prs[3];
   assign unused_lvl = ^lvl;

`ifdef AUTO_REPEAT_EN
   localparam int RW = $clog2(50 * DEBOUNCE_CYCLES + 1);
   logic [RW-1:0] rpt_cnt;
   logic          rpt_armed, held_inc, held_dec, rpt_fire;

   assign held_inc = lvl[1] & ~lvl[2];
   assign held_dec = lvl[2] & ~lvl[1];
   // First repeat after the long delay, later ones at the short interval.
   assign rpt_fire = editing & (held_inc | held_dec) & ~inc_p & ~dec_p &
                     (rpt_armed ? (rpt_cnt == RW'(20 * DEBOUNCE_CYCLES - 1))
                                : (rpt_cnt == RW'(50 * DEBOUNCE_CYCLES - 1)));

   always_ff @(posedge clk) begin
      if (reset || !editing || !(held_inc || held_dec) || inc_p || dec_p) begin
         rpt_cnt   <= '0;
         rpt_armed <= 1'b0;
      end else if (rpt_fire) begin
         rpt_cnt   <= '0;
         rpt_armed <= 1'b1;
      end else begin
         rpt_cnt <= rpt_cnt + RW'(1);
      end
   end

   assign inc_step = inc_p | (rpt_fire & held_inc);
   assign dec_step = dec_p | (rpt_fire & held_dec);
`else
   assign inc_step = inc_p;
   assign dec_step = dec_p;
`endif

   assign editing    = (st == SET_HR) || (st == SET_MIN) || (st == SET_SEC);
   assign editing_nx = (st_nx == SET_HR) || (st_nx == SET_MIN) || (st_nx == SET_SEC);
   assign step_any   = editing & (inc_step | dec_step);
   // Mode and cancel both pre-empt arithmetic in the same cycle.
   assign do_arith   = editing & ~cancel_p & ~mode_p & (inc_step ^ dec_step);

   always_comb begin
      st_nx = st;
      case (st)
         IDLE:    if (mode_p) st_nx = SET_HR;
         SET_HR:  if (cancel_p) st_nx = IDLE; else if (mode_p) st_nx = SET_MIN;
         SET_MIN: if (cancel_p) st_nx = IDLE; else if (mode_p) st_nx = SET_SEC;
         SET_SEC: if (cancel_p) st_nx = IDLE; else if (mode_p) st_nx = COMMIT;
         default: st_nx = IDLE;
      endcase
   end

   always_comb begin
      fld_max = MS_MAX;
      case (st)
         SET_HR: begin
            fld     = shadow[H1_LSB +: 8];
            fld_max = HR_MAX;
         end
         SET_MIN: fld = shadow[M1_LSB +: 8];
         default: fld = shadow[S1_LSB +: 8];
      endcase
      fld_nx = inc_step ? bcd_inc(fld, fld_max) : bcd_dec(fld, fld_max);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st     <= IDLE;
         shadow <= '0;
      end else begin
         st <= st_nx;
         if (st == IDLE && mode_p) begin
            shadow <= cur_time;
         end else if (do_arith) begin
            case (st)
               SET_HR:  shadow[H1_LSB +: 8] <= fld_nx;
               SET_MIN: shadow[M1_LSB +: 8] <= fld_nx;
               default: shadow[S1_LSB +: 8] <= fld_nx;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || !editing_nx || st_nx != st) begin
         bcnt  <= '0;
         phase <= 1'b0;
      end else if (bcnt == BW'(BLINK_CYCLES - 1)) begin
         bcnt  <= '0;
         phase <= ~phase;
      end else begin
         bcnt <= bcnt + BW'(1);
      end
   end

   // Keeps the just-edited value lit for a full blink half-period after each step.
   always_ff @(posedge clk) begin
      if (reset || !editing) hold <= '0;
      else if (step_any)     hold <= BW'(BLINK_CYCLES);
      else if (hold != '0)   hold <= hold - BW'(1);
   end

   assign blink_mask   = (editing && phase && hold == '0 && !step_any) ? field_mask(st) : 6'b000000;
   assign bus.set_time = shadow;
   assign bus.load     = (st == COMMIT);
   assign state        = st;

endmodule
